// File: rtl/exp2_arb_pkg.sv
// exp2_arb_pkg: shared defaults and types for the exp2 round-robin arbiter.
//   NUM_REQ_DEF          default number of requesters
//   BF_DEF               default fractional bit count of the fixed-point operand
//   FIX_POINT_WIDTH_DEF  default operand/result width
//   arb_state_t          response-register state (EMPTY / FULL)
package exp2_arb_pkg;

    localparam int NUM_REQ_DEF         = 4;
    localparam int BF_DEF              = 8;
    localparam int FIX_POINT_WIDTH_DEF = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/exp2.sv
// exp2: combinational base-2 exponent of a signed Q(W-Bf).Bf operand.
//   in   [W-1:0]  signed fixed-point operand x
//   u    [W-1:0]  signed integer part floor(x), sign-extended to W bits
//   out  [W-1:0]  unsigned Q(W-Bf).Bf approximation of 2^x, saturating at all-ones
// 2^frac is approximated by 1 + f*(21/32 + 11/32*f), which is exact at f=0 and
// f=1 and within about 0.3% in between; the mantissa is then shifted by u.
// Requires 5 <= Bf < W so that both coefficients are exact in Bf bits.
module exp2 #(
    parameter int Bf              = 8,
    parameter int FIX_POINT_WIDTH = 16
) (
    input  logic [FIX_POINT_WIDTH-1:0] in,
    output logic [FIX_POINT_WIDTH-1:0] u,
    output logic [FIX_POINT_WIDTH-1:0] out
);

    localparam int W  = FIX_POINT_WIDTH;
    localparam int PW = 2 * Bf + 2;
    localparam int SW = 2 * W;
    localparam int C1 = (21 << Bf) >> 5;
    localparam int C2 = (11 << Bf) >> 5;
    localparam logic [W-1:0] W_LIM = W'(W);

    logic [Bf-1:0]   frac;
    logic [W-1:0]    ipart;
    logic [W-1:0]    shamt_neg;
    logic [PW-1:0]   t_prod;
    logic [PW-1:0]   s_sum;
    logic [PW-1:0]   m_prod;
    logic [Bf+1:0]   mant;
    logic [SW-1:0]   wide;

    assign frac      = in[Bf-1:0];
    assign ipart     = W'($signed(in) >>> Bf);
    assign shamt_neg = -ipart;
    assign u         = ipart;

    assign t_prod = PW'(frac) * PW'(C2);
    assign s_sum  = PW'(C1) + (t_prod >> Bf);
    assign m_prod = PW'(frac) * s_sum;
    assign mant   = (Bf+2)'((PW'(1) << Bf) + (m_prod >> Bf));

    always_comb begin
        wide = '0;
        out  = '0;
        if (!ipart[W-1]) begin
            if (ipart >= W_LIM) begin
                out = '1;
            end else begin
                wide = SW'(mant) << ipart;
                // Anything above the result width means the value overflowed.
                if (|wide[SW-1:W]) begin
                    out = '1;
                end else begin
                    out = wide[W-1:0];
                end
            end
        end else begin
            if (shamt_neg >= W_LIM) begin
                out = '0;
            end else begin
                out = W'(mant >> shamt_neg);
            end
        end
    end

endmodule

// File: rtl/exp2_arbiter_rr_pick.sv
// rr_pick: round-robin priority picker.
//   req  [N-1:0]      request vector
//   ptr  [IDX_W-1:0]  index with highest priority this cycle (must be < N)
//   gnt  [N-1:0]      one-hot grant (zero when no request)
//   idx  [IDX_W-1:0]  encoded grant index (0 when no request)
//   any               at least one request is granted
module rr_pick
    import exp2_arb_pkg::*;
#(
    parameter int N     = NUM_REQ_DEF,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N);

    // pos[k] is the requester examined k steps after ptr; rot is req rotated so
    // that a plain lowest-bit-first search implements the circular search.
    logic [IDX_W-1:0] pos [N];
    logic [N-1:0]     rot;

    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        logic [IDX_W:0] pos_sum;
        assign pos_sum = {1'b0, ptr} + (IDX_W+1)'(gi);
        assign pos[gi] = (pos_sum >= N_W) ? IDX_W'(pos_sum - N_W) : IDX_W'(pos_sum);
        assign rot[gi] = req[pos[gi]];
    end

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        // Walk downward so the candidate closest to ptr is written last.
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                any = 1'b1;
                idx = pos[k];
            end
        end
        if (any) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/exp2_arbiter.sv
// exp2_arbiter: shares one combinational exp2 unit among NUM_REQ requesters.
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   req_valid  [NUM_REQ]          requester i has an operand
//   req_data   [NUM_REQ*W]        slice i is requester i's operand
//   req_ready  [NUM_REQ]          one-hot accept of the granted requester
//   rsp_valid                     response register holds a result
//   rsp_ready                     consumer takes the response this cycle
//   rsp_id     [ID_W]             requester that owns the response
//   rsp_u      [W]                registered exp2.u
//   rsp_out    [W]                registered exp2.out
// Build option EXP2_ARB_PRIO0_EN: requester 0 gets strict priority and does
// not move the round-robin pointer; requesters 1..NUM_REQ-1 rotate among
// themselves. Undefined (default): all requesters are pure round-robin.
module exp2_arbiter
    import exp2_arb_pkg::*;
#(
    parameter int NUM_REQ         = NUM_REQ_DEF,
    parameter int Bf              = BF_DEF,
    parameter int FIX_POINT_WIDTH = FIX_POINT_WIDTH_DEF,
    parameter int ID_W            = $clog2(NUM_REQ)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*FIX_POINT_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [ID_W-1:0]                    rsp_id,
    output logic [FIX_POINT_WIDTH-1:0]         rsp_u,
    output logic [FIX_POINT_WIDTH-1:0]         rsp_out
);

    localparam int W = FIX_POINT_WIDTH;
    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_REQ - 1);

    arb_state_t         state_reg, state_next;
    logic [ID_W-1:0]    rr_ptr_reg, rr_ptr_next;
    logic               can_accept;
    logic               accept;
    logic [NUM_REQ-1:0] pick_req, pick_gnt, gnt;
    logic [ID_W-1:0]    pick_idx, gnt_idx;
    logic               pick_any, gnt_any;
    logic [W-1:0]       masked_data [NUM_REQ];
    logic [W-1:0]       exp_in, exp_u, exp_out;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_rr_pick (
        .req (pick_req),
        .ptr (rr_ptr_reg),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

`ifdef EXP2_ARB_PRIO0_EN
    // Requester 0 bypasses the rotation entirely.
    assign pick_req = {req_valid[NUM_REQ-1:1], 1'b0};

    always_comb begin
        if (req_valid[0]) begin
            gnt     = NUM_REQ'(1);
            gnt_idx = '0;
            gnt_any = 1'b1;
        end else begin
            gnt     = pick_gnt;
            gnt_idx = pick_idx;
            gnt_any = pick_any;
        end
    end
`else
    assign pick_req = req_valid;
    assign gnt      = pick_gnt;
    assign gnt_idx  = pick_idx;
    assign gnt_any  = pick_any;
`endif

    // A full register can still accept if it is being drained this cycle.
    assign can_accept = (state_reg == EMPTY) | rsp_ready;
    assign accept     = can_accept & gnt_any & ~rst;
    assign req_ready  = accept ? gnt : '0;

    // One-hot AND-OR operand mux; zero when nothing is granted.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mux
        assign masked_data[gi] = req_ready[gi] ? req_data[gi*W +: W] : '0;
    end

    always_comb begin
        exp_in = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            exp_in |= masked_data[k];
        end
    end

    exp2 #(
        .Bf              (Bf),
        .FIX_POINT_WIDTH (FIX_POINT_WIDTH)
    ) u_exp2 (
        .in  (exp_in),
        .u   (exp_u),
        .out (exp_out)
    );

    always_comb begin
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        if (accept) begin
            state_next = FULL;
`ifdef EXP2_ARB_PRIO0_EN
            if (gnt_idx != '0) begin
                rr_ptr_next = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
            end
`else
            rr_ptr_next = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
`endif
        end else if ((state_reg == FULL) && rsp_ready) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= EMPTY;
            rr_ptr_reg <= '0;
            rsp_id     <= '0;
            rsp_u      <= '0;
            rsp_out    <= '0;
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
            if (accept) begin
                rsp_id  <= gnt_idx;
                rsp_u   <= exp_u;
                rsp_out <= exp_out;
            end
        end
    end

    assign rsp_valid = (state_reg == FULL);

endmodule

// File: tb/tb_exp2_arbiter.sv
// tb_exp2_arbiter: scoreboard bench for exp2_arbiter (NUM_REQ=4, Bf=8, W=16).
// The stimulus process predicts each grant and pushes the hand-computed exp2
// result for the granted operand; the monitor pops and compares whenever a
// response is presented. Honors EXP2_ARB_PRIO0_EN when the build defines it.
module tb_exp2_arbiter;

    localparam int NR   = 4;
    localparam int W    = 16;
    localparam int ID_W = 2;
    localparam int NTV  = 14;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*W-1:0]   req_data  = '0;
    logic [NR-1:0]     req_ready;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [ID_W-1:0]   rsp_id;
    logic [W-1:0]      rsp_u;
    logic [W-1:0]      rsp_out;

    exp2_arbiter #(
        .NUM_REQ         (NR),
        .Bf              (8),
        .FIX_POINT_WIDTH (W),
        .ID_W            (ID_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_u     (rsp_u),
        .rsp_out   (rsp_out)
    );

    always #5 clk = ~clk;

    // Hand-computed vectors: 2^frac ~ 1 + f*(168 + (88*f>>8))/256 in Q.8,
    // then shifted by the integer part (saturating / flushing to zero).
    logic [W-1:0] tv_in  [NTV] = '{16'h0000, 16'h0180, 16'h0040, 16'h02C0, 16'hFF80,
                                   16'h0300, 16'h0780, 16'h0800, 16'h8000, 16'h0140,
                                   16'h01C0, 16'hFF00, 16'hF800, 16'hF700};
    logic [W-1:0] tv_u   [NTV] = '{16'h0000, 16'h0001, 16'h0000, 16'h0002, 16'hFFFF,
                                   16'h0003, 16'h0007, 16'h0008, 16'hFF80, 16'h0001,
                                   16'h0001, 16'hFFFF, 16'hFFF8, 16'hFFF7};
    logic [W-1:0] tv_out [NTV] = '{16'h0100, 16'h02D4, 16'h012F, 16'h06BC, 16'h00B5,
                                   16'h0800, 16'hB500, 16'hFFFF, 16'h0000, 16'h025E,
                                   16'h035E, 16'h0080, 16'h0001, 16'h0000};

    int sel [NR] = '{0, 0, 0, 0};

    int n_checks = 0;
    int n_pass   = 0;
    int n_rsp    = 0;

    logic [ID_W+2*W-1:0] sb_q [$];

    int   model_ptr  = 0;
    logic model_full = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int model_pick(input logic [NR-1:0] v, input int ptr);
`ifdef EXP2_ARB_PRIO0_EN
        if (v[0]) return 0;
`endif
        for (int k = 0; k < NR; k++) begin
            int i;
            i = (ptr + k) % NR;
`ifdef EXP2_ARB_PRIO0_EN
            if (i == 0) continue;
`endif
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // One cycle: drive at posedge+1, check req_ready at negedge, record the
    // accept at the posedge.
    task automatic run_cycle(input logic [NR-1:0] v, input logic rr, output int g);
        logic [NR-1:0] exp_rdy;
        req_valid = v;
        rsp_ready = rr;
        for (int i = 0; i < NR; i++) req_data[i*W +: W] = tv_in[sel[i]];
        @(negedge clk);
        g       = -1;
        exp_rdy = '0;
        if (!model_full || rr) g = model_pick(v, model_ptr);
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        @(posedge clk);
        if (g >= 0) begin
            sb_q.push_back({ID_W'(g), tv_u[sel[g]], tv_out[sel[g]]});
            model_full = 1'b1;
`ifdef EXP2_ARB_PRIO0_EN
            if (g != 0)
`endif
                model_ptr = (g + 1) % NR;
        end else if (rr) begin
            model_full = 1'b0;
        end
        #1;
    endtask

    // Monitor: every presented response must match the oldest expected one.
    initial begin
        logic [ID_W+2*W-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("rsp_valid", 64'(rsp_valid), 64'(sb_q.size() != 0));
                if (rsp_valid && sb_q.size() != 0) begin
                    e = sb_q[0];
                    chk("rsp_id_u_out", 64'({rsp_id, rsp_u, rsp_out}), 64'(e));
                    if (rsp_ready) begin
                        void'(sb_q.pop_front());
                        n_rsp++;
                        $display("rsp %0d: id=%0d u=%h out=%h", n_rsp, rsp_id, rsp_u, rsp_out);
                    end
                end
            end
        end
    end

    int fair_exp [8];
    int wait_cnt [NR] = '{0, 0, 0, 0};

    initial begin
        int g;
        logic [NR-1:0] pend;
        logic [NR-1:0] nv;
        logic rr;

`ifdef EXP2_ARB_PRIO0_EN
        fair_exp = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
        fair_exp = '{1, 2, 3, 0, 1, 2, 3, 0};
`endif

        // Reset state, with requests pending to show req_ready is held low.
        #1 rst = 1'b1;
        req_valid = '1;
        #2;
        chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset_rsp_id",    64'(rsp_id),    64'(0));
        chk("reset_rsp_u",     64'(rsp_u),     64'(0));
        chk("reset_rsp_out",   64'(rsp_out),   64'(0));
        chk("reset_req_ready", 64'(req_ready), 64'(0));
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single request: operand 1.5 on requester 0.
        sel[0] = 1;
        run_cycle(4'b0001, 1'b1, g);
        chk("single_grant", 64'(g), 64'(0));
        run_cycle(4'b0000, 1'b1, g);

        // Fairness with everyone valid and the consumer always ready.
        sel = '{0, 2, 3, 4};
        for (int c = 0; c < 8; c++) begin
            run_cycle(4'b1111, 1'b1, g);
            chk("fair_order", 64'(g), 64'(fair_exp[c]));
        end

        // Backpressure: register full, consumer stalled for 5 cycles.
        sel = '{5, 9, 10, 11};
        for (int c = 0; c < 5; c++) begin
            run_cycle(4'b1111, 1'b0, g);
            chk("stall_no_grant", 64'(g), 64'(-1));
        end
        run_cycle(4'b1111, 1'b1, g);
        run_cycle(4'b0000, 1'b1, g);

        // A requester that withdraws before being accepted leaves no trace.
        run_cycle(4'b1000, 1'b0, g);
        run_cycle(4'b0010, 1'b0, g);
        run_cycle(4'b0010, 1'b0, g);
        run_cycle(4'b0000, 1'b1, g);

        // Reset while holding a result for requester 2.
        sel[2] = 3;
        run_cycle(4'b0100, 1'b0, g);
        chk("pre_reset_grant", 64'(g), 64'(2));
        rst = 1'b1;
        req_valid = '1;
        #1;
        chk("async_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("async_rsp_id",    64'(rsp_id),    64'(0));
        chk("async_rsp_u",     64'(rsp_u),     64'(0));
        chk("async_rsp_out",   64'(rsp_out),   64'(0));
        chk("async_req_ready", 64'(req_ready), 64'(0));
        sb_q.delete();
        model_full = 1'b0;
        model_ptr  = 0;
        req_valid  = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_cycle(4'b1111, 1'b1, g);
        chk("post_reset_grant", 64'(g), 64'(0));
        run_cycle(4'b0000, 1'b1, g);

        // Every vector once, rotated over the requesters.
        for (int k = 0; k < NTV; k++) begin
            sel[k % NR] = k;
            run_cycle(NR'(1 << (k % NR)), 1'b1, g);
            chk("sweep_grant", 64'(g), 64'(k % NR));
        end
        run_cycle(4'b0000, 1'b1, g);

        // Random mix; requests stay up until accepted so wait can be bounded.
        pend = '0;
        for (int c = 0; c < 300; c++) begin
            nv = pend | NR'($urandom_range(0, 15));
            for (int i = 0; i < NR; i++) begin
                if (nv[i] && !pend[i]) sel[i] = int'($urandom_range(0, NTV - 1));
            end
            rr = ($urandom_range(0, 3) != 0);
            run_cycle(nv, rr, g);
            pend = nv;
            if (g >= 0) begin
                pend[g] = 1'b0;
                for (int i = 0; i < NR; i++) begin
                    if (pend[i]) wait_cnt[i]++;
                    else wait_cnt[i] = 0;
`ifndef EXP2_ARB_PRIO0_EN
                    if (pend[i]) chk("wait_bound", 64'(wait_cnt[i] < NR), 64'(1));
`endif
                end
            end
        end
        run_cycle(4'b0000, 1'b1, g);
        run_cycle(4'b0000, 1'b1, g);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/exp2_arbiter.md
# exp2_arbiter

Shares one combinational `exp2` unit between `NUM_REQ` requesters using round-robin arbitration. Each requester presents a Q(16-`Bf`).`Bf` operand over a valid/ready handshake. The arbiter grants at most one operand per cycle, evaluates it through the shared `exp2`, and captures `u`/`out` together with the requester index in a one-entry response register. It sits between the nonlinear-function clients and the `exp2` datapath, and serializes all base-2 exponent requests.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..8.
- `Bf`, default 8: fractional bits, passed through to `exp2`.
- `FIX_POINT_WIDTH`, default 16: operand and result width, passed through to `exp2`.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the response tag.
- Reset is asynchronous and active-high. There is one clock, `clk`, and one reset, `rst`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  `NUM_REQ`  bit i: requester i has an operand.
- `req_data`  in  `NUM_REQ*FIX_POINT_WIDTH`  slice i holds requester i's operand.
- `req_ready`  out  `NUM_REQ`  one-hot or zero; bit i: operand i is accepted this cycle.
- `rsp_valid`  out  1  response register is full.
- `rsp_ready`  in  1  consumer takes the response this cycle.
- `rsp_id`  out  `ID_W`  index of the requester that owns the response.
- `rsp_u`  out  `FIX_POINT_WIDTH`  registered `exp2.u`.
- `rsp_out`  out  `FIX_POINT_WIDTH`  registered `exp2.out`.

## Operation
- State machine has two states:
  - EMPTY: response register free.
  - FULL: response register holds an unconsumed result.
- `can_accept = (state==EMPTY) | rsp_ready`.
- Grant is computed combinationally when `can_accept` is 1:
  - Search starts at `rr_ptr` and proceeds upward modulo `NUM_REQ`.
  - The first index i with `req_valid[i]` gets `req_ready[i]=1`.
  - All other `req_ready` bits are 0. With no valid request, `req_ready=0`.
- The muxed operand of the granted requester drives the single `exp2.in`. `exp2.in` is 0 when nothing is granted.
- On a grant (accept):
  - `rsp_u`, `rsp_out` and `rsp_id` load from the shared `exp2` and the grant index.
  - State becomes FULL.
  - `rr_ptr` becomes (granted index + 1) mod `NUM_REQ`.
- FULL with `rsp_ready=1` and a new grant in the same cycle: the register reloads and stays FULL. There is no bubble and no lost result.
- FULL with `rsp_ready=1` and no grant: state goes to EMPTY. Data outputs hold their last values.
- FULL with `rsp_ready=0`: all outputs hold, `req_ready=0`, `rr_ptr` holds.
- `rr_ptr` changes only on an accept, so no requester starves.
- `req_ready` never depends combinationally on `req_data`.
- Requesters may drop `req_valid` without being accepted; no state is affected.

## Timing
- Reset values: `rsp_valid=0`, `rsp_id=0`, `rsp_u=0`, `rsp_out=0`, `rr_ptr=0`, state EMPTY. `req_ready` is 0 while `rst` is high.
- Latency: an operand accepted at edge k gives `rsp_valid=1` with its result after edge k.
- Throughput: one result per cycle while `rsp_ready` is held at 1.
- Reset asserted mid-operation discards any held response immediately (asynchronous). No response is emitted for it after reset releases.
- First cycle after reset release: a grant is allowed if `req_valid` is set.

## Configuration
- `EXP2_ARB_PRIO0_EN`
  - Defined: requester 0 has strict priority. It is granted whenever `req_valid[0]` and `can_accept` are both 1, regardless of `rr_ptr`. `rr_ptr` is not updated on a requester-0 grant. Requesters 1..`NUM_REQ`-1 are round-robin among themselves.
  - Undefined: all requesters are pure round-robin, as described in Operation.

## Structure
- Shared package `exp2_arb_pkg`:
  - localparam defaults for `NUM_REQ`, `Bf`, `FIX_POINT_WIDTH`.
  - typedef for the state enum (EMPTY, FULL).
- Sub-module `rr_pick`: parameterized round-robin priority picker.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, encoded index, any-grant flag.
- `exp2` is instantiated once, unchanged.

## Test plan
- Single request: after reset, `req_valid=4'b0001`, `req_data[0]=16'h0180`, `rsp_ready=1`.
  - Expect `req_ready=4'b0001` in the same cycle.
  - Next cycle expect `rsp_valid=1`, `rsp_id=0`, and `rsp_out`/`rsp_u` equal to a standalone `exp2` for 16'h0180 (`out` nominally 2^1.5, about 16'h02D4).
- Fairness: all four requesters valid continuously, `rsp_ready=1`.
  - Grant order 0,1,2,3,0,1… with one response per cycle.
  - `rsp_id` sequence matches the grant order.
- Backpressure: response FULL and `rsp_ready=0` for 5 cycles with requests pending.
  - `req_ready=0` and outputs stable throughout.
  - On `rsp_ready=1`, the next grant loads in the same cycle and no result is lost or duplicated.
- Reset mid-operation: assert `rst` while FULL with `rsp_id=2`.
  - `rsp_valid`, `rsp_id`, `rsp_u`, `rsp_out` go to 0 without a clock edge.
  - After release, the first grant starts from requester 0.
- Priority macro: with `EXP2_ARB_PRIO0_EN` defined, all requesters valid.
  - Requester 0 is granted every cycle and 1–3 are never granted.
  - Without the macro, the same stimulus gives round-robin order.
- Random: constrained-random `req_valid`/`req_data` and `rsp_ready` for 10k cycles, checked by a scoreboard.
  - Each requester's results arrive in order, with correct `rsp_id` and matching the reference `exp2`.
  - No requester waits more than `NUM_REQ` accepts.
